// File: rtl/aidan_mcnay_divrem_defs.sv
// Shared definitions for the iterative divide/remainder unit.
// Holds the controller state encoding used by aidan_mcnay_itr_divrem.
package aidan_mcnay_divrem_defs;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/aidan_mcnay_divrem_step.sv
// One radix-2 restoring division iteration, purely combinational.
// Shifts the next dividend bit into the partial remainder, trial-subtracts
// the divisor and keeps or restores depending on the borrow. Kept separate
// so an unrolled or pipelined divider can chain copies of it.
module aidan_mcnay_divrem_step #(
  parameter int nbits = 16
) (
  input  logic [nbits:0]   i_rem,
  input  logic [nbits-1:0] i_quo,
  input  logic [nbits-1:0] i_divisor,
  output logic [nbits:0]   o_rem,
  output logic [nbits-1:0] o_quo
);

  logic [nbits+1:0] w_shifted;
  logic [nbits+1:0] w_diff;
  logic             w_borrow;

  // Trial subtraction; the partial remainder is always below the divisor, so
  // its top bit is 0 and the extra bit of width only carries the borrow.
  always_comb begin
    w_shifted = {i_rem, i_quo[nbits-1]};
    w_diff    = w_shifted - {2'b00, i_divisor};
    w_borrow  = w_diff[nbits+1];
    o_rem     = w_borrow ? w_shifted[nbits:0] : w_diff[nbits:0];
    o_quo     = {i_quo[nbits-2:0], ~w_borrow};
  end

endmodule

// File: rtl/aidan_mcnay_itr_divrem.sv
// Iterative radix-2 restoring divider returning quotient and remainder of
// opa/opb with a divide-by-zero flag, behind val/rdy streams on both sides.
// Normal operations spend exactly nbits cycles in CALC; a zero divisor goes
// straight to DONE.
// Build option: define AIDAN_MCNAY_ITR_DIVREM_EARLY_EXIT_EN to also send
// opb > opa straight to DONE (quotient 0, remainder opa).
module aidan_mcnay_itr_divrem
  import aidan_mcnay_divrem_defs::*;
#(
  parameter int nbits = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [nbits-1:0] opa,
  input  logic [nbits-1:0] opb,
  input  logic             istream_val,
  output logic             istream_rdy,
  output logic [nbits-1:0] quotient,
  output logic [nbits-1:0] remainder,
  output logic             div_by_zero,
  output logic             ostream_val,
  input  logic             ostream_rdy
);

  localparam int CW = $clog2(nbits) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(nbits - 1);

`ifdef AIDAN_MCNAY_ITR_DIVREM_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  state_t           r_state;
  state_t           w_state_next;
  logic [nbits:0]   r_rem;
  logic [nbits:0]   w_rem_next;
  logic [nbits-1:0] r_quo;
  logic [nbits-1:0] w_quo_next;
  logic [nbits-1:0] r_divisor;
  logic [nbits-1:0] w_divisor_next;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_next;
  logic             r_dbz;
  logic             w_dbz_next;

  logic [nbits:0]   w_step_rem;
  logic [nbits-1:0] w_step_quo;

  aidan_mcnay_divrem_step #(
    .nbits(nbits)
  ) u_step (
    .i_rem    (r_rem),
    .i_quo    (r_quo),
    .i_divisor(r_divisor),
    .o_rem    (w_step_rem),
    .o_quo    (w_step_quo)
  );

  // Next-state and datapath update; everything holds unless a branch says otherwise.
  always_comb begin
    w_state_next   = r_state;
    w_rem_next     = r_rem;
    w_quo_next     = r_quo;
    w_divisor_next = r_divisor;
    w_count_next   = r_count;
    w_dbz_next     = r_dbz;
    case (r_state)
      IDLE: begin
        if (istream_val) begin
          w_dbz_next = 1'b0;
          if (opb == '0) begin
            w_state_next = DONE;
            w_dbz_next   = 1'b1;
            w_quo_next   = '1;
            w_rem_next   = {1'b0, opa};
          end else if (EARLY_EXIT && (opb > opa)) begin
            w_state_next = DONE;
            w_quo_next   = '0;
            w_rem_next   = {1'b0, opa};
          end else begin
            w_state_next   = CALC;
            w_divisor_next = opb;
            w_quo_next     = opa;
            w_rem_next     = '0;
            w_count_next   = '0;
          end
        end
      end
      CALC: begin
        w_rem_next   = w_step_rem;
        w_quo_next   = w_step_quo;
        w_count_next = r_count + CW'(1);
        if (r_count == LAST_ITER) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (ostream_rdy) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_count   <= '0;
      r_dbz     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_rem     <= w_rem_next;
      r_quo     <= w_quo_next;
      r_divisor <= w_divisor_next;
      r_count   <= w_count_next;
      r_dbz     <= w_dbz_next;
    end
  end

  assign istream_rdy = (r_state == IDLE);
  assign ostream_val = (r_state == DONE);
  assign quotient    = r_quo;
  assign remainder   = r_rem[nbits-1:0];
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_aidan_mcnay_itr_divrem.sv
// Self-checking bench for aidan_mcnay_itr_divrem (nbits = 16).
// Latency here is the number of rising edges after the accepting edge before
// ostream_val is visible: nbits on the CALC path, 0 when the result is
// already presented in the cycle right after the accept.
module tb_aidan_mcnay_itr_divrem;

  localparam int N = 16;
  localparam logic [N-1:0] ONES = '1;
`ifdef AIDAN_MCNAY_ITR_DIVREM_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] opa = '0;
  logic [N-1:0] opb = '0;
  logic         istream_val = 1'b0;
  logic         istream_rdy;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;
  logic         ostream_val;
  logic         ostream_rdy = 1'b0;

  int checks = 0;
  int errors = 0;

  aidan_mcnay_itr_divrem #(.nbits(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .opa        (opa),
    .opb        (opb),
    .istream_val(istream_val),
    .istream_rdy(istream_rdy),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .ostream_val(ostream_val),
    .ostream_rdy(ostream_rdy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: plain integer division plus the zero-divisor convention.
  function automatic void ref_divrem(input logic [N-1:0] a, input logic [N-1:0] b,
                                     output logic [N-1:0] q, output logic [N-1:0] r,
                                     output logic z, output int lat);
    if (b == 0) begin
      q = ONES; r = a; z = 1'b1; lat = 0;
    end else begin
      q = a / b; r = a % b; z = 1'b0;
      lat = (EE && (b > a)) ? 0 : N;
    end
  endfunction

  // Present one operation from IDLE, wait for the result, stall, then take it.
  task automatic drive_op(input logic [N-1:0] a, input logic [N-1:0] b, input int stall,
                          output int lat, output logic [N-1:0] q, output logic [N-1:0] r,
                          output logic z, output bit timeout);
    @(negedge clk);
    opa = a; opb = b; istream_val = 1'b1; ostream_rdy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    istream_val = 1'b0;
    lat = 0;
    while (!ostream_val && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    timeout = !ostream_val;
    q = quotient; r = remainder; z = div_by_zero;
    repeat (stall) @(negedge clk);
    ostream_rdy = 1'b1;
    @(negedge clk);
    ostream_rdy = 1'b0;
    $display("op %0d/%0d -> q=%0d r=%0d dbz=%0b lat=%0d", a, b, q, r, z, lat);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({istream_rdy, ostream_val} !== 2'b10) begin
      errors++;
      $display("FAIL reset_handshake: got rdy=%0b val=%0b expected rdy=1 val=0", istream_rdy, ostream_val);
    end
    checks++;
    if ({quotient, remainder, div_by_zero} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got q=%h r=%h dbz=%0b expected all 0", quotient, remainder, div_by_zero);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (istream_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_rdy: got %0b expected 1", istream_rdy);
    end
  endtask

  task automatic test_basic();
    logic [N-1:0] q, r; logic z; int lat; bit to;
    drive_op(16'd100, 16'd7, 0, lat, q, r, z, to);
    checks++;
    if (to || lat !== N) begin
      errors++;
      $display("FAIL basic_latency: got %0d (timeout=%0b) expected %0d", lat, to, N);
    end
    checks++;
    if ({q, r, z} !== {16'd14, 16'd2, 1'b0}) begin
      errors++;
      $display("FAIL basic_result: got q=%0d r=%0d dbz=%0b expected q=14 r=2 dbz=0", q, r, z);
    end
  endtask

  task automatic test_div_zero();
    logic [N-1:0] q, r; logic z; int lat; bit to;
    drive_op(16'd5, 16'd0, 0, lat, q, r, z, to);
    checks++;
    if (to || lat !== 0) begin
      errors++;
      $display("FAIL dbz_latency: got %0d (timeout=%0b) expected 0", lat, to);
    end
    checks++;
    if ({q, r, z} !== {16'hFFFF, 16'd5, 1'b1}) begin
      errors++;
      $display("FAIL dbz_result: got q=%h r=%0d dbz=%0b expected q=ffff r=5 dbz=1", q, r, z);
    end
    drive_op(16'd9, 16'd3, 0, lat, q, r, z, to);
    checks++;
    if (to || {q, r, z} !== {16'd3, 16'd0, 1'b0}) begin
      errors++;
      $display("FAIL dbz_followup: got q=%0d r=%0d dbz=%0b (timeout=%0b) expected q=3 r=0 dbz=0", q, r, z, to);
    end
  endtask

  task automatic test_small_over_large();
    logic [N-1:0] q, r; logic z; int lat; bit to;
    int exp_lat;
    exp_lat = EE ? 0 : N;
    drive_op(16'd3, 16'd10, 0, lat, q, r, z, to);
    checks++;
    if (to || lat !== exp_lat) begin
      errors++;
      $display("FAIL small_latency: got %0d (timeout=%0b) expected %0d", lat, to, exp_lat);
    end
    checks++;
    if ({q, r, z} !== {16'd0, 16'd3, 1'b0}) begin
      errors++;
      $display("FAIL small_result: got q=%0d r=%0d dbz=%0b expected q=0 r=3 dbz=0", q, r, z);
    end
    drive_op(16'd0, 16'd77, 0, lat, q, r, z, to);
    checks++;
    if (to || {q, r, z} !== {16'd0, 16'd0, 1'b0}) begin
      errors++;
      $display("FAIL zero_dividend: got q=%0d r=%0d dbz=%0b expected q=0 r=0 dbz=0", q, r, z);
    end
  endtask

  task automatic test_max_operands();
    logic [N-1:0] q, r; logic z; int lat; bit to; int n; bit rdy_bad;
    drive_op(16'hFFFF, 16'd1, 0, lat, q, r, z, to);
    checks++;
    if (to || {q, r, z} !== {16'hFFFF, 16'd0, 1'b0}) begin
      errors++;
      $display("FAIL max_div1: got q=%h r=%h dbz=%0b expected q=ffff r=0 dbz=0", q, r, z);
    end
    // Second operation keeps istream_val high with different operands during CALC.
    @(negedge clk);
    opa = 16'hFFFF; opb = 16'hFFFF; istream_val = 1'b1;
    @(posedge clk);
    @(negedge clk);
    opa = 16'd5; opb = 16'd0;
    n = 0; rdy_bad = 1'b0;
    while (!ostream_val && n < 64) begin
      if (istream_rdy !== 1'b0) rdy_bad = 1'b1;
      @(negedge clk);
      n++;
    end
    istream_val = 1'b0;
    checks++;
    if (rdy_bad || n !== N) begin
      errors++;
      $display("FAIL max_busy: got rdy_seen_high=%0b lat=%0d expected rdy_seen_high=0 lat=%0d", rdy_bad, n, N);
    end
    checks++;
    if ({quotient, remainder, div_by_zero} !== {16'd1, 16'd0, 1'b0}) begin
      errors++;
      $display("FAIL max_equal: got q=%0d r=%0d dbz=%0b expected q=1 r=0 dbz=0", quotient, remainder, div_by_zero);
    end
    $display("op ffff/ffff with val held -> q=%0d r=%0d lat=%0d", quotient, remainder, n);
    ostream_rdy = 1'b1;
    @(negedge clk);
    ostream_rdy = 1'b0;
  endtask

  task automatic test_backpressure();
    int n; bit to;
    @(negedge clk);
    opa = 16'd1000; opb = 16'd33; istream_val = 1'b1; ostream_rdy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    istream_val = 1'b0;
    n = 0;
    while (!ostream_val && n < 64) begin
      @(negedge clk);
      n++;
    end
    to = !ostream_val;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (to || {ostream_val, istream_rdy, quotient, remainder} !== {1'b1, 1'b0, 16'd30, 16'd10}) begin
        errors++;
        $display("FAIL stall_hold_%0d: got val=%0b rdy=%0b q=%0d r=%0d expected val=1 rdy=0 q=30 r=10",
                 i, ostream_val, istream_rdy, quotient, remainder);
      end
    end
    ostream_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if ({ostream_val, istream_rdy} !== 2'b01) begin
      errors++;
      $display("FAIL stall_transfer: got val=%0b rdy=%0b expected val=0 rdy=1", ostream_val, istream_rdy);
    end
    @(negedge clk);
    checks++;
    if (ostream_val !== 1'b0) begin
      errors++;
      $display("FAIL stall_single: got val=%0b expected 0", ostream_val);
    end
    ostream_rdy = 1'b0;
    $display("op 1000/33 stalled 5 cycles -> single transfer");
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] q, r; logic z; int lat; bit to;
    @(negedge clk);
    opa = 16'd1234; opb = 16'd5; istream_val = 1'b1;
    @(posedge clk);
    @(negedge clk);
    istream_val = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if ({istream_rdy, ostream_val} !== 2'b00) begin
      errors++;
      $display("FAIL midcalc_busy: got rdy=%0b val=%0b expected rdy=0 val=0", istream_rdy, ostream_val);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({istream_rdy, ostream_val, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 33'd0}) begin
      errors++;
      $display("FAIL midcalc_reset: got rdy=%0b val=%0b q=%h r=%h dbz=%0b expected rdy=1 val=0 q=0 r=0 dbz=0",
               istream_rdy, ostream_val, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    reset = 1'b1;
    drive_op(16'd1234, 16'd5, 0, lat, q, r, z, to);
    checks++;
    if (to || lat !== N || {q, r, z} !== {16'd246, 16'd4, 1'b0}) begin
      errors++;
      $display("FAIL after_reset: got q=%0d r=%0d dbz=%0b lat=%0d expected q=246 r=4 dbz=0 lat=%0d",
               q, r, z, lat, N);
    end
  endtask

  task automatic test_back_to_back();
    int seen; int first; int last; bit spacing_bad; bit q_bad;
    seen = 0; first = -1; last = -1; spacing_bad = 1'b0; q_bad = 1'b0;
    @(negedge clk);
    opa = 16'd100; opb = 16'd7; istream_val = 1'b1; ostream_rdy = 1'b1;
    for (int k = 0; k <= 3 * N + 5; k++) begin
      @(negedge clk);
      if (ostream_val) begin
        if (quotient !== 16'd14 || remainder !== 16'd2) q_bad = 1'b1;
        if (last >= 0 && (k - last) != N + 2) spacing_bad = 1'b1;
        if (first < 0) first = k;
        last = k;
        seen++;
      end
    end
    istream_val = 1'b0;
    ostream_rdy = 1'b0;
    checks++;
    if (seen !== 3 || spacing_bad || first !== N || q_bad) begin
      errors++;
      $display("FAIL back_to_back: got transfers=%0d first=%0d spacing_bad=%0b q_bad=%0b expected 3 transfers, first=%0d, spacing %0d",
               seen, first, spacing_bad, q_bad, N, N + 2);
    end
    $display("back_to_back 100/7 x%0d first at %0d", seen, first);
    repeat (N + 3) @(negedge clk);
    ostream_rdy = 1'b1;
    @(negedge clk);
    ostream_rdy = 1'b0;
  endtask

  task automatic test_random();
    logic [N-1:0] a, b, q, r, eq, er; logic z, ez; int lat, el; bit to;
    int mode;
    for (int i = 0; i < 30; i++) begin
      mode = $urandom_range(0, 4);
      a = N'($urandom);
      case (mode)
        0: b = N'($urandom);
        1: b = N'($urandom_range(1, 15));
        2: b = '0;
        3: begin a = N'($urandom_range(0, 1000)); b = a + N'($urandom_range(1, 100)); end
        default: b = N'($urandom_range(0, 300));
      endcase
      ref_divrem(a, b, eq, er, ez, el);
      drive_op(a, b, $urandom_range(0, 3), lat, q, r, z, to);
      checks++;
      if (to || lat !== el || {q, r, z} !== {eq, er, ez}) begin
        errors++;
        $display("FAIL random_%0d: %0d/%0d got q=%0d r=%0d dbz=%0b lat=%0d expected q=%0d r=%0d dbz=%0b lat=%0d",
                 i, a, b, q, r, z, lat, eq, er, ez, el);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_small_over_large();
    test_max_operands();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
